// File: rtl/div_iter_param.sv
// div_iter_param: iterative radix-2^RBITS restoring divider, signed/unsigned, with
// valid/ready handshakes, flush abort and divide-by-zero/overflow shortcuts.
module div_iter_param #(
   parameter int WIDTH = 32,
   parameter int RBITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int ITER = (WIDTH + RBITS - 1) / RBITS;
   localparam int DW   = ITER * RBITS;
   localparam int PW   = WIDTH + RBITS;
   localparam int CW   = $clog2(ITER + 1);
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
   state_t           state_q, state_d;
   logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    sh_q, sh_d;
   logic [WIDTH-1:0] dm_q, dm_d, pr_q, pr_d, q_q, q_d, quo_q, quo_d, rem_q, rem_d;
   logic [PW-1:0]    shv, prod, sub;
   logic [RBITS-1:0] dig;
   logic [WIDTH-1:0] a_op;
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? -v : v;
   endfunction
   // During PREP the shift register still holds the raw dividend in its low bits.
   assign a_op        = sh_q[WIDTH-1:0];
   assign shv         = {pr_q, sh_q[DW-1 -: RBITS]};
   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   // Largest digit whose multiple of the divisor still fits; multiples grow monotonically.
   always_comb begin
      dig  = '0;
      sub  = '0;
      prod = '0;
      for (int j = 1; j < (1 << RBITS); j++) begin
         prod = PW'(dm_q) * PW'(j);
         if (prod <= shv) begin
            dig = RBITS'(j);
            sub = prod;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      dm_d    = dm_q;
      pr_d    = pr_q;
      q_d     = q_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            state_d = S_PREP;
            sgn_d   = is_signed;
            sh_d    = DW'(dividend_in);
            dm_d    = divisor_in;
         end
         S_PREP: begin
            qneg_d  = sgn_q & (a_op[WIDTH-1] ^ dm_q[WIDTH-1]);
            rneg_d  = sgn_q & a_op[WIDTH-1];
            cnt_d   = CW'(ITER);
            sh_d    = DW'(mag(a_op, sgn_q));
            dm_d    = mag(dm_q, sgn_q);
            pr_d    = '0;
            q_d     = '0;
            dbz_d   = 1'b0;
            state_d = S_ITER;
            if (dm_q == '0) begin
               state_d = S_DONE;
               quo_d   = '1;
               rem_d   = a_op;
               dbz_d   = 1'b1;
            end else if (sgn_q && a_op == {1'b1, {(WIDTH-1){1'b0}}} && &dm_q) begin
               state_d = S_DONE;
               quo_d   = a_op;
               rem_d   = '0;
            end
         end
         S_ITER: begin
            pr_d  = WIDTH'(shv - sub);
            q_d   = {q_q[WIDTH-RBITS-1:0], dig};
            sh_d  = sh_q << RBITS;
            cnt_d = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_FIX : S_ITER;
         end
         S_FIX: begin
            quo_d   = qneg_q ? -q_q : q_q;
            rem_d   = rneg_q ? -pr_q : pr_q;
            state_d = S_DONE;
         end
         S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
         cnt_q   <= '0;
         sh_q    <= '0;
         dm_q    <= '0;
         pr_q    <= '0;
         q_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dm_q    <= dm_d;
         pr_q    <= pr_d;
         q_q     <= q_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end
endmodule

// File: tb/tb_div_iter_param.sv
// tb_div_iter_param: directed checks of the default 32-bit divider and an 8-bit radix-2
// instance, including special cases, stalls, aborts and a reference-model sweep.
module tb_div_iter_param;
   logic        clk = 1'b0, rst, flush;
   logic        a_in_valid, a_in_ready, a_is_signed, a_out_valid, a_out_ready, a_dbz;
   logic [31:0] a_dvd, a_dvs, a_q, a_r;
   logic        b_in_valid, b_in_ready, b_is_signed, b_out_valid, b_out_ready, b_dbz;
   logic [7:0]  b_dvd, b_dvs, b_q, b_r;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   div_iter_param u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .is_signed(a_is_signed), .dividend_in(a_dvd), .divisor_in(a_dvs), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .quotient(a_q), .remainder(a_r), .div_by_zero(a_dbz));
   div_iter_param #(.WIDTH(8), .RBITS(1)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .is_signed(b_is_signed), .dividend_in(b_dvd), .divisor_in(b_dvs), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .quotient(b_q), .remainder(b_r), .div_by_zero(b_dbz));
   task automatic launch_a(input logic s, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      a_is_signed = s; a_dvd = x; a_dvs = y; a_in_valid = 1'b1;
      @(posedge clk);
      #1 a_in_valid = 1'b0;
      a_dvd = $urandom; a_dvs = $urandom; a_is_signed = ~s;
   endtask
   task automatic wait_a(output int lat);
      lat = 0;
      while (!a_out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask
   task automatic pop_a();
      a_out_ready = 1'b1;
      @(posedge clk);
      #1 a_out_ready = 1'b0;
   endtask
   task automatic launch_b(input logic s, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      b_is_signed = s; b_dvd = x; b_dvs = y; b_in_valid = 1'b1;
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      b_dvd = 8'($urandom); b_dvs = 8'($urandom); b_is_signed = ~s;
   endtask
   task automatic wait_b(output int lat);
      lat = 0;
      while (!b_out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      a_in_valid = 0; a_is_signed = 0; a_dvd = 0; a_dvs = 0; a_out_ready = 0;
      b_in_valid = 0; b_is_signed = 0; b_dvd = 0; b_dvs = 0; b_out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
      checks++;
      if (a_q !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", a_q); end
      checks++;
      if (a_r !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", a_r); end
      checks++;
      if (a_dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", a_dbz); end
      checks++;
   endtask
   task automatic test_basic();
      int lat;
      launch_a(1'b0, 32'd100, 32'd7);
      wait_a(lat);
      if (lat !== 13) begin errors++; $display("FAIL basic_latency got %0d want 13", lat); end
      checks++;
      if (a_q !== 32'd14) begin errors++; $display("FAIL basic_quotient got %h want %h", a_q, 32'd14); end
      checks++;
      if (a_r !== 32'd2) begin errors++; $display("FAIL basic_remainder got %h want %h", a_r, 32'd2); end
      checks++;
      if (a_dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", a_dbz); end
      checks++;
      pop_a();
   endtask
   task automatic test_signed();
      logic        s[6]  = '{1, 0, 1, 1, 0, 0};
      logic [31:0] x[6]  = '{32'hFFFFFF9C, 32'hFFFFFFFF, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'd7};
      logic [31:0] y[6]  = '{32'd7, 32'd1, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd100};
      logic [31:0] eq[6] = '{32'hFFFFFFF2, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'd14, 32'h24924916, 32'd0};
      logic [31:0] er[6] = '{32'hFFFFFFFE, 32'd0, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd7};
      int lat;
      for (int i = 0; i < 6; i++) begin
         launch_a(s[i], x[i], y[i]);
         wait_a(lat);
         if (lat !== 13 || a_q !== eq[i] || a_r !== er[i] || a_dbz !== 1'b0) begin
            errors++;
            $display("FAIL signed_%0d got lat=%0d q=%h r=%h z=%b want lat=13 q=%h r=%h z=0", i, lat, a_q, a_r, a_dbz, eq[i], er[i]);
         end
         checks++;
         pop_a();
      end
   endtask
   task automatic test_special();
      logic        s[5]  = '{0, 1, 1, 1, 0};
      logic [31:0] x[5]  = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
      logic [31:0] y[5]  = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] eq[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0};
      logic [31:0] er[5] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'd0, 32'h80000000};
      logic        ez[5] = '{1, 1, 1, 0, 0};
      int          el[5] = '{1, 1, 1, 1, 13};
      int lat;
      for (int i = 0; i < 5; i++) begin
         launch_a(s[i], x[i], y[i]);
         wait_a(lat);
         if (lat !== el[i] || a_q !== eq[i] || a_r !== er[i] || a_dbz !== ez[i]) begin
            errors++;
            $display("FAIL special_%0d got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b", i, lat, a_q, a_r, a_dbz, el[i], eq[i], er[i], ez[i]);
         end
         checks++;
         pop_a();
      end
   endtask
   task automatic test_stall();
      int lat;
      launch_a(1'b0, 32'd1000, 32'd7);
      wait_a(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (a_out_valid !== 1'b1 || a_q !== 32'd142 || a_r !== 32'd6 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_%0d got v=%b q=%h r=%h rdy=%b want v=1 q=%h r=%h rdy=0", i, a_out_valid, a_q, a_r, a_in_ready, 32'd142, 32'd6);
         end
         checks++;
      end
      pop_a();
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++; $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", a_out_valid, a_in_ready);
      end
      checks++;
   endtask
   task automatic test_abort();
      int lat;
      logic seen;
      for (int m = 0; m < 2; m++) begin
         launch_a(1'b0, 32'd1000, 32'd3);
         repeat (5) @(posedge clk);
         #1;
         if (m == 0) begin
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
         end else begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
         end
         #1;
         if (a_in_ready !== 1'b1) begin errors++; $display("FAIL abort%0d_in_ready got %b want 1", m, a_in_ready); end
         checks++;
         seen = 1'b0;
         repeat (20) begin
            @(posedge clk);
            #1 seen |= a_out_valid;
         end
         if (seen !== 1'b0) begin errors++; $display("FAIL abort%0d_no_result got out_valid=%b want 0", m, seen); end
         checks++;
         launch_a(1'b0, 32'd45, 32'd6);
         wait_a(lat);
         if (lat !== 13 || a_q !== 32'd7 || a_r !== 32'd3) begin
            errors++; $display("FAIL abort%0d_next got lat=%0d q=%h r=%h want lat=13 q=7 r=3", m, lat, a_q, a_r);
         end
         checks++;
         pop_a();
      end
   endtask
   task automatic test_narrow();
      int lat, el;
      logic s, ez;
      logic [7:0] x, y, eq, er;
      logic signed [7:0] xs, ys;
      launch_b(1'b0, 8'd200, 8'd3);
      wait_b(lat);
      if (lat !== 10 || b_q !== 8'd66 || b_r !== 8'd2 || b_dbz !== 1'b0) begin
         errors++; $display("FAIL narrow_200_3 got lat=%0d q=%h r=%h z=%b want lat=10 q=42 r=02 z=0", lat, b_q, b_r, b_dbz);
      end
      checks++;
      b_out_ready = 1'b1;
      @(posedge clk);
      #1 b_out_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         s = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: x = 8'h80;
            1: x = 8'hFF;
            2: x = 8'h00;
            default: x = 8'($urandom);
         endcase
         case ($urandom_range(0, 6))
            0: y = 8'h00;
            1: y = 8'hFF;
            2: y = 8'h01;
            3: y = 8'h80;
            default: y = 8'($urandom);
         endcase
         xs = x; ys = y;
         if (y == 8'h00) begin eq = 8'hFF; er = x; ez = 1'b1; el = 1; end
         else if (s && x == 8'h80 && y == 8'hFF) begin eq = 8'h80; er = 8'h00; ez = 1'b0; el = 1; end
         else if (s) begin eq = xs / ys; er = xs % ys; ez = 1'b0; el = 10; end
         else begin eq = x / y; er = x % y; ez = 1'b0; el = 10; end
         launch_b(s, x, y);
         wait_b(lat);
         if (lat !== el || b_q !== eq || b_r !== er || b_dbz !== ez) begin
            errors++;
            $display("FAIL narrow_rand_%0d s=%b %h/%h got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b", i, s, x, y, lat, b_q, b_r, b_dbz, el, eq, er, ez);
         end
         checks++;
         b_out_ready = 1'b1;
         @(posedge clk);
         #1 b_out_ready = 1'b0;
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_special();
      test_stall();
      test_abort();
      test_narrow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_iter_param.md
DIV_ITER_PARAM -- requirements
Module: div_iter_param

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width; legal range 8..64.
REQ-002 Parameter RBITS, default 3: quotient bits retired per iteration; legal range 1..4.
REQ-003 Derived constant ITER = ceil(WIDTH/RBITS) SHALL set the iteration count (WIDTH=32, RBITS=3 gives 11).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 flush  input  1  synchronous abort of any in-flight or pending operation.
REQ-007 in_valid  input  1  request operands valid.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 is_signed  input  1  1 = two's-complement div/rem, 0 = unsigned; sampled on acceptance.
REQ-010 dividend_in  input  WIDTH  dividend; sampled on acceptance.
REQ-011 divisor_in  input  WIDTH  divisor; sampled on acceptance.
REQ-012 out_valid  output  1  quotient/remainder valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 quotient  output  WIDTH  result quotient.
REQ-015 remainder  output  WIDTH  result remainder.
REQ-016 div_by_zero  output  1  result produced by divide-by-zero rule; qualified by out_valid.

Function
REQ-017 FSM states SHALL be IDLE, PREP, ITER, FIX, DONE; one operation in flight.
REQ-018 in_ready SHALL be 1 only in IDLE; acceptance = in_valid && in_ready at an edge (edge k); IDLE->PREP, operands and is_signed registered.
REQ-019 PREP: take magnitudes (negate operand if is_signed and MSB set); record quotient sign = dividend MSB xor divisor MSB, remainder sign = dividend MSB (both 0 when unsigned); load iteration counter with ITER.
REQ-020 PREP with divisor == 0: go DONE at edge k+1 with quotient = all ones, remainder = original dividend, div_by_zero = 1.
REQ-021 PREP with is_signed, dividend = most-negative value, divisor = all ones: go DONE at edge k+1 with quotient = most-negative value, remainder = 0.
REQ-022 Otherwise PREP->ITER at edge k+1.
REQ-023 ITER: partial remainder WIDTH+RBITS bits wide, dividend magnitude zero-extended to ITER*RBITS bits and consumed MSB-first RBITS per cycle.
REQ-024 Each ITER cycle: shift next RBITS dividend bits into partial remainder; digit d = largest of 0..2^RBITS-1 with d*divisor_mag <= shifted value; subtract d*divisor_mag; shift d into quotient LSBs; decrement counter.
REQ-025 ITER->FIX after exactly ITER iterations (edge k+1+ITER).
REQ-026 FIX: negate quotient if quotient sign set; negate remainder if remainder sign set; drive outputs; FIX->DONE at edge k+ITER+2.
REQ-027 Normal latency: out_valid first high after edge k+ITER+2 (k+13 for defaults); special cases after edge k+1.
REQ-028 Results SHALL satisfy dividend = quotient*divisor + remainder, |remainder| < |divisor|, remainder sign = dividend sign (or zero), truncating toward zero.
REQ-029 DONE: out_valid = 1; quotient, remainder, div_by_zero held stable while out_ready = 0.
REQ-030 DONE with out_ready = 1 at an edge: ->IDLE, out_valid drops next cycle; in_ready rises the same cycle (no overlap with prior result).
REQ-031 flush = 1 at an edge: ->IDLE from any state, out_valid = 0, result discarded; flush has priority over acceptance and out_ready.
REQ-032 Input changes while not IDLE SHALL not affect the operation in flight.

Reset
REQ-033 rst = 1 SHALL immediately force IDLE, in_ready = 1 after release, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0, sign flags = 0.
REQ-034 rst mid-operation SHALL abort it with no result; first edge after release may accept a new request.

Verification
REQ-035 Defaults, unsigned 100/7 accepted at edge k -> out_valid after edge k+13, quotient 14, remainder 2.
REQ-036 Signed 0xFFFFFF9C/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-037 0x12345678/0 (either mode) -> out_valid after edge k+1, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-038 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready 0; out_ready = 1 -> in_ready 1 next cycle.
REQ-039 Assert rst, then in separate runs flush, at iteration 5 -> out_valid never rises; following request 45/6 -> quotient 7, remainder 3.
REQ-040 WIDTH=8, RBITS=1 (ITER=8): unsigned 200/3 -> out_valid after edge k+10, quotient 66, remainder 2; random signed/unsigned compare against reference model.
